// File: rtl/ddr_axi_pkg.sv
// Shared constants, FSM state type and sizing helper for the DDR read-port
// arbiter.
package ddr_axi_pkg;

  localparam int AXI_LEN_W  = 8;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    ARB      = 2'd1,
    ISSUE    = 2'd2
  } arb_state_e;

  // Ceiling log2, never less than 1, so a 1-entry index still has a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ddr_rd_id_fifo.sv
// In-order ID FIFO: remembers which requester owns each outstanding burst.
// The head is read combinationally so returning data can be routed with
// zero latency. DEPTH must be a power of two so the pointers wrap naturally.
module ddr_rd_id_fifo
  import ddr_axi_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2_min1(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage write; entries need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one DDR controller read port among NUM_REQ
// requesters. AR requests are granted one at a time and held until the
// controller accepts them; R bursts return in issue order and are steered
// to their owner using an ID FIFO.
// Optional build macro DDR_RD_ARB_STATS_EN adds per-requester grant counters
// and a full-FIFO stall counter.
module ddr_rd_arbiter
  import ddr_axi_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_OUT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ddr_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]    s_araddr,
  input  logic [NUM_REQ*AXI_LEN_W-1:0] s_arlen,
  input  logic [NUM_REQ-1:0]           s_arvalid,
  output logic [NUM_REQ-1:0]           s_arready,
  output logic [DATA_W-1:0]            s_rdata,
  output logic                         s_rlast,
  output logic [NUM_REQ-1:0]           s_rvalid,
  input  logic [NUM_REQ-1:0]           s_rready,
  output logic [ADDR_W-1:0]            araddr,
  output logic [AXI_LEN_W-1:0]         arlen,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [DATA_W-1:0]            rdata,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready,
  output logic                         busy
`ifdef DDR_RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]        grant_cnt,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int IDX_W = clog2_min1(NUM_REQ);
  localparam int CNT_W = clog2_min1(MAX_OUT) + 1;

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0]    araddr_q, araddr_d;
  logic [AXI_LEN_W-1:0] arlen_q, arlen_d;
  logic                 arvalid_q, arvalid_d;

  logic [IDX_W-1:0]     win_idx;
  logic                 any_req;
  logic                 grant;
  logic [ADDR_W-1:0]    win_addr;
  logic [AXI_LEN_W-1:0] win_len;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [IDX_W-1:0]     fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_pop;

  assign any_req  = |s_arvalid;
  assign grant    = (state_q == ARB) && any_req && !fifo_full;
  assign win_addr = s_araddr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_len  = s_arlen[int'(win_idx)*AXI_LEN_W +: AXI_LEN_W];

  // Round-robin search: first set request after the last winner, wrapping.
  // Walking offsets from farthest to nearest lets the nearest one win.
  always_comb begin : p_winner
    int cand;
    cand    = 0;
    win_idx = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = (int'(ptr_q) + off) % NUM_REQ;
      if (s_arvalid[cand]) win_idx = IDX_W'(cand);
    end
  end

  // Single-cycle accept strobe for the winning requester only.
  always_comb begin
    s_arready = '0;
    if (grant) s_arready[win_idx] = 1'b1;
  end

  // FSM next state: wait for controller init, arbitrate, then hold the AR.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    case (state_q)
      WAIT_RDY: begin
        if (ddr_ready) state_d = ARB;
      end
      ARB: begin
        if (grant) begin
          araddr_d  = win_addr;
          arlen_d   = win_len;
          arvalid_d = 1'b1;
          ptr_d     = win_idx;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = ARB;
        end
      end
      default: state_d = WAIT_RDY;
    endcase
  end

  // FSM and AR output registers; the pointer resets so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_RDY;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
    end
  end

  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arvalid = arvalid_q;

  ddr_rd_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_data (win_idx),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // R steering: only the owner of the oldest burst sees rvalid, and only its
  // ready reaches the controller. Stray rvalid with nothing tracked is never
  // acknowledged.
  always_comb begin
    s_rvalid = '0;
    rready   = 1'b0;
    if (!fifo_empty) begin
      s_rvalid[fifo_head] = rvalid;
      rready              = s_rready[fifo_head];
    end
  end

  assign fifo_pop = rvalid && rready && rlast;
  assign s_rdata  = rdata;
  assign s_rlast  = rlast;
  assign busy     = (fifo_count != '0) || arvalid_q;

`ifdef DDR_RD_ARB_STATS_EN
  logic [15:0] stall_cnt_q;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
    logic [15:0] cnt_q;

    // Saturating count of grants won by requester gi.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (grant && (win_idx == IDX_W'(gi)) && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end

    assign grant_cnt[gi*16 +: 16] = cnt_q;
  end

  // Saturating count of arbitration cycles lost to a full ID FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ARB) && any_req && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed self-checking bench for ddr_rd_arbiter (NUM_REQ=2, MAX_OUT=4).
module tb_ddr_rd_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ddr_ready;
  logic [NUM_REQ*ADDR_W-1:0] s_araddr;
  logic [NUM_REQ*8-1:0]  s_arlen;
  logic [NUM_REQ-1:0]    s_arvalid;
  logic [NUM_REQ-1:0]    s_arready;
  logic [DATA_W-1:0]     s_rdata;
  logic                  s_rlast;
  logic [NUM_REQ-1:0]    s_rvalid;
  logic [NUM_REQ-1:0]    s_rready;
  logic [ADDR_W-1:0]     araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_W-1:0]     rdata;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  logic                  busy;
`ifdef DDR_RD_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
  logic [15:0]           stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ddr_rd_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ddr_ready (ddr_ready),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rlast   (s_rlast),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .araddr    (araddr),
    .arlen     (arlen),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .busy      (busy)
`ifdef DDR_RD_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  localparam logic [31:0] ADDR0 = 32'h0000_0FFF;
  localparam logic [31:0] ADDR1 = 32'h0000_1000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq [3];
    int drain_seq [4];
    exp_seq   = '{1, 0, 1};
    drain_seq = '{1, 0, 1, 0};

    rst = 1'b1; ddr_ready = 1'b0; s_araddr = '0; s_arlen = '0; s_arvalid = '0;
    s_rready = '0; arready = 1'b0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
    step(); step(); settle();
    check("rst_arvalid", arvalid, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_busy", busy, 0);
    check("rst_rready", rready, 0);
    check("rst_s_rvalid", s_rvalid, 0);
    check("rst_s_arready", s_arready, 0);

    // Controller not ready: no grants at all.
    rst = 1'b0;
    s_araddr = {ADDR1, ADDR0};
    s_arvalid = 2'b11;
    for (int i = 0; i < 20; i++) begin
      step(); settle();
      check("wait_s_arready", s_arready, 0);
      check("wait_arvalid", arvalid, 0);
    end

    ddr_ready = 1'b1;
    step(); settle();
    check("first_grant", s_arready, 2'b01);
    ddr_ready = 1'b0; // ignored from now on
    step(); settle();
    check("first_arvalid", arvalid, 1);
    check("first_araddr", araddr, ADDR0);
    check("issue_no_grant", s_arready, 0);
    check("busy_issue", busy, 1);

    // Stalled controller: AR stays stable.
    for (int i = 0; i < 5; i++) begin
      step(); settle();
      check("hold_arvalid", arvalid, 1);
      check("hold_araddr", araddr, ADDR0);
      check("hold_arlen", arlen, 0);
      check("hold_s_arready", s_arready, 0);
    end
    arready = 1'b1;
    settle();
    check("hs_cycle_s_arready", s_arready, 0);
    step(); settle();
    check("post_hs_arvalid", arvalid, 0);

    // Continue round-robin 1,0,1 with a fast controller.
    for (int k = 0; k < 3; k++) begin
      check("rr_grant", s_arready, 2'b01 << exp_seq[k]);
      step(); settle();
      check("rr_arvalid", arvalid, 1);
      check("rr_araddr", araddr, (exp_seq[k] == 1) ? ADDR1 : ADDR0);
      step(); settle();
      check("rr_arvalid_1cyc", arvalid, 0);
    end

    // Four outstanding: FIFO full, no grant.
    check("full_no_grant", s_arready, 0);
`ifdef DDR_RD_ARB_STATS_EN
    check("stall_cnt_0", stall_cnt, 0);
`endif
    step(); step(); settle();
    check("full_no_grant2", s_arready, 0);
    check("full_arvalid", arvalid, 0);
`ifdef DDR_RD_ARB_STATS_EN
    check("stall_cnt_2", stall_cnt, 2);
`endif

    // One single-beat burst returns for requester 0.
    s_rready = 2'b11; rvalid = 1'b1; rlast = 1'b1; rdata = 32'hA5A5_0001;
    settle();
    check("ret_s_rvalid", s_rvalid, 2'b01);
    check("ret_rready", rready, 1);
    check("ret_s_rdata", s_rdata, 32'hA5A5_0001);
    check("ret_s_rlast", s_rlast, 1);
    step();
    rvalid = 1'b0; rlast = 1'b0;
    settle();
    check("resume_grant", s_arready, 2'b01);
`ifdef DDR_RD_ARB_STATS_EN
    check("stall_cnt_3", stall_cnt, 3);
`endif
    step(); settle();
    check("resume_araddr", araddr, ADDR0);
    step(); settle();
    s_arvalid = 2'b00;

    // Drain: owners in issue order 1,0,1,0.
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; rlast = 1'b1; rdata = 32'h100 + k;
      settle();
      check("drain_s_rvalid", s_rvalid, 2'b01 << drain_seq[k]);
      check("drain_rready", rready, 1);
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;
    settle();
    check("drained_busy", busy, 0);
`ifdef DDR_RD_ARB_STATS_EN
    check("grant_cnt", grant_cnt, 32'h0002_0003);
`endif
    rvalid = 1'b1;
    settle();
    check("stray_rready", rready, 0);
    check("stray_s_rvalid", s_rvalid, 0);
    rvalid = 1'b0;

    // Multi-beat routing: req1 len 3, then req0 len 0.
    s_arlen = {8'd3, 8'd0};
    s_arvalid = 2'b10;
    settle();
    check("b_grant1", s_arready, 2'b10);
    step(); settle();
    check("b_arlen1", arlen, 3);
    check("b_araddr1", araddr, ADDR1);
    step();
    s_arvalid = 2'b01;
    settle();
    check("b_grant0", s_arready, 2'b01);
    step(); settle();
    check("b_arlen0", arlen, 0);
    step();
    s_arvalid = 2'b00;

    rvalid = 1'b1; rlast = 1'b0; s_rready = 2'b11;
    settle();
    check("beat0_s_rvalid", s_rvalid, 2'b10);
    check("beat0_rready", rready, 1);
    step();
    s_rready = 2'b01;
    settle();
    check("beat1_stall_rready", rready, 0);
    check("beat1_stall_s_rvalid", s_rvalid, 2'b10);
    step();
    s_rready = 2'b11;
    settle();
    check("beat1_rready", rready, 1);
    step();
    step();
    rlast = 1'b1;
    settle();
    check("beat3_s_rvalid", s_rvalid, 2'b10);
    step();
    s_rready = 2'b01;
    settle();
    check("beat4_s_rvalid", s_rvalid, 2'b01);
    check("beat4_rready", rready, 1);
    step();
    rvalid = 1'b0; rlast = 1'b0;
    settle();
    check("b_busy", busy, 0);

    // Reset during ISSUE with two outstanding.
    s_arvalid = 2'b11; arready = 1'b1;
    settle();
    check("c_grant1", s_arready, 2'b10);
    step(); step(); settle();
    check("c_grant0", s_arready, 2'b01);
    arready = 1'b0;
    step(); settle();
    check("c_issue_arvalid", arvalid, 1);
    rst = 1'b1;
    step(); settle();
    check("c_rst_arvalid", arvalid, 0);
    check("c_rst_busy", busy, 0);
    check("c_rst_araddr", araddr, 0);
    rst = 1'b0; ddr_ready = 1'b1;
    settle();
    check("c_wait_no_grant", s_arready, 0);
    step(); settle();
    check("c_first_grant", s_arready, 2'b01);
`ifdef DDR_RD_ARB_STATS_EN
    check("c_grant_cnt", grant_cnt, 0);
    check("c_stall_cnt", stall_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
